// File: rtl/noc_defs.sv
// Shared NoC definitions: flit type codes, output port indices, input-port
// FSM states and the XY routing helper used by every input port.
package noc_defs;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_STREAM  = 2'd2,
    ST_RELIEVE = 2'd3
  } ipc_state_e;

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
  function automatic port_e xy_route(input int dest, input int self_id, input int mesh_x);
    int dest_x, dest_y, self_x, self_y;
    dest_x = dest % mesh_x;
    dest_y = dest / mesh_x;
    self_x = self_id % mesh_x;
    self_y = self_id / mesh_x;
    if (dest_x > self_x)      return PORT_EAST;
    else if (dest_x < self_x) return PORT_WEST;
    else if (dest_y > self_y) return PORT_NORTH;
    else if (dest_y < self_y) return PORT_SOUTH;
    else                      return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer for one input port. Show-ahead: the head flit is always visible
// on 'head' so the route can be computed before it is popped.
module flit_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,     // asynchronous, active-low
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  push,    // caller guarantees !full
  input  logic                  pop,     // caller guarantees !empty
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Flit storage write port.
  // NOTE: the storage array has no reset; 'count' alone decides which entries
  // are meaningful, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is 2^AW).
  // NOTE: every clocked register uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_controller.sv
// Router input port: buffers flits, XY-routes the head flit, reserves a
// crossbar path, streams the packet and releases the path after the tail.
module input_port_controller
  import noc_defs::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int N             = 4,
  parameter int MESH_X        = 2,
  parameter int ROUTER_ID     = 0,
  parameter int BUFFER_DEPTH  = 4,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,   // asynchronous, active-low
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic                     routeReserveStatus,
  output logic                     routeRelieve,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     protocol_error
);

  localparam int DEST_W = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0]    fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     discard;
  flit_type_e               head_type;
  logic                     head_is_head;
  logic                     head_is_tail;
  port_e                    head_route;
  ipc_state_e               state;
  logic [REQUEST_WIDTH-1:0] route_q;

  flit_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_data(data_in),
    .push   (push),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Head-flit decode: type bit 0 marks a head, bit 1 marks a tail.
  assign head_type    = flit_type_e'(fifo_head[DATA_WIDTH-1 -: 2]);
  assign head_is_head = head_type[0];
  assign head_is_tail = head_type[1];
  assign head_route   = xy_route(int'(fifo_head[DEST_W-1:0]), ROUTER_ID, MESH_X);

  // Upstream side accepts whenever there is room, in every state.
  assign ready_in = ~fifo_full;
  assign push     = valid_in & ~fifo_full;

  // Switch side: flits only leave while a granted path is held. data_out is
  // forced to zero when idle so no stale buffer contents leak after reset.
  assign valid_out           = (state == ST_STREAM) & ~fifo_empty;
  assign data_out            = valid_out ? fifo_head : '0;
  assign routeReserveRequest = route_q;

  // Pop on a switch handshake, or to drop a stray non-head flit while idle.
  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    discard = 1'b0;
    pop     = 1'b0;
    if (state == ST_IDLE && !fifo_empty && !head_is_head) discard = 1'b1;
    pop = (valid_out & ready_out) | discard;
  end

  // Packet FSM with registered request/relieve/error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= ST_IDLE;
      route_q                  <= '0;
      routeReserveRequestValid <= 1'b0;
      routeRelieve             <= 1'b0;
      protocol_error           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_is_head) begin
              route_q                  <= REQUEST_WIDTH'(head_route);
              routeReserveRequestValid <= 1'b1;
              state                    <= ST_REQ;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (routeReserveStatus) begin
            routeReserveRequestValid <= 1'b0;
            state                    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (valid_out && ready_out && head_is_tail) begin
            routeRelieve <= 1'b1;
            state        <= ST_RELIEVE;
          end
        end
        ST_RELIEVE: begin
          routeRelieve <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller: routing table, latency, back-pressure,
// protocol error and mid-packet reset, with a flit scoreboard on the switch side.
module tb_input_port_controller;
  import noc_defs::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          status = 1'b0;
  logic          ready_out = 1'b0;

  logic          ready_in, req_valid, relieve, valid_out, perr;
  logic [2:0]    request;
  logic [DW-1:0] data_out;

  logic          d3_ready_in, d3_req_valid, d3_relieve, d3_valid_out, d3_perr;
  logic [2:0]    d3_request;
  logic [DW-1:0] d3_data_out;

  int            total = 0;
  int            bad = 0;
  int            relieve_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [3:0]    seq = '0;

  typedef struct {
    logic [1:0] dest;
    int         nflits;
    logic [2:0] exp_r0;
    logic [2:0] exp_r3;
  } pkt_vec_t;

  pkt_vec_t tbl[5];

  always #5 clk = ~clk;

  input_port_controller #(.ROUTER_ID(0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .routeReserveRequestValid(req_valid), .routeReserveRequest(request),
    .routeReserveStatus(status), .routeRelieve(relieve), .data_out(data_out),
    .valid_out(valid_out), .ready_out(ready_out), .protocol_error(perr)
  );

  input_port_controller #(.ROUTER_ID(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(d3_ready_in),
    .routeReserveRequestValid(d3_req_valid), .routeReserveRequest(d3_request),
    .routeReserveStatus(status), .routeRelieve(d3_relieve), .data_out(d3_data_out),
    .valid_out(d3_valid_out), .ready_out(ready_out), .protocol_error(d3_perr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input flit_type_e t, input logic [1:0] dest);
    seq = seq + 4'd1;
    return {t, seq, dest};
  endfunction

  // Switch-side monitor: scoreboard every transferred flit, count relieve pulses.
  always @(negedge clk) begin
    if (rst && relieve) relieve_cnt++;
    if (rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL flit_unexpected: got=%0h expected=none", data_out);
      end else begin
        check("flit_order", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_flit(input logic [DW-1:0] f, input bit expect_out);
    bit ok = 1'b0;
    data_in  = f;
    valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_in) begin ok = 1'b1; break; end
    end
    check("push_accept", {31'd0, ok}, 32'd1);
    if (ok && expect_out) exp_q.push_back(f);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic finish_packet(input string name, input int start);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (relieve_cnt != start) break;
    end
    repeat (3) @(negedge clk);
    check({name, "_relieve_once"}, relieve_cnt - start, 32'd1);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle_no_valid"}, {31'd0, valid_out}, 32'd0);
  endtask

  task automatic run_packet(input string name, input logic [1:0] dest, input int nflits,
                            input logic [2:0] e0, input logic [2:0] e3);
    int start = relieve_cnt;
    fork
      begin
        if (nflits == 1) push_flit(mk(FLIT_HEADTAIL, dest), 1'b1);
        else begin
          push_flit(mk(FLIT_HEAD, dest), 1'b1);
          for (int k = 1; k < nflits - 1; k++) push_flit(mk(FLIT_BODY, dest), 1'b1);
          push_flit(mk(FLIT_TAIL, dest), 1'b1);
        end
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (req_valid) begin seen = 1'b1; break; end
        end
        check({name, "_req_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
          check({name, "_route_r0"}, {29'd0, request}, {29'd0, e0});
          check({name, "_route_r3"}, {29'd0, d3_request}, {29'd0, e3});
        end
      end
    join
    finish_packet(name, start);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit seen;

    tbl[0] = '{dest: 2'd3, nflits: 3, exp_r0: PORT_EAST,  exp_r3: PORT_LOCAL};
    tbl[1] = '{dest: 2'd0, nflits: 1, exp_r0: PORT_LOCAL, exp_r3: PORT_WEST};
    tbl[2] = '{dest: 2'd2, nflits: 2, exp_r0: PORT_NORTH, exp_r3: PORT_WEST};
    tbl[3] = '{dest: 2'd1, nflits: 1, exp_r0: PORT_EAST,  exp_r3: PORT_SOUTH};
    tbl[4] = '{dest: 2'd3, nflits: 4, exp_r0: PORT_EAST,  exp_r3: PORT_LOCAL};

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_request", {29'd0, request}, 32'd0);
    check("rst_relieve", {31'd0, relieve}, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    check("rst3_ready_in", {31'd0, d3_ready_in}, 32'd1);
    check("rst3_outs", {18'd0, d3_req_valid, d3_request, d3_relieve, d3_valid_out, d3_data_out, d3_perr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    status = 1'b1;
    ready_out = 1'b1;

    // Minimum latency of a single-flit packet
    start = relieve_cnt;
    push_flit(mk(FLIT_HEADTAIL, 2'd1), 1'b1);
    @(negedge clk);
    check("lat_req_edge0", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    check("lat_req_edge1", {31'd0, req_valid}, 32'd1);
    check("lat_route_r0", {29'd0, request}, {29'd0, PORT_EAST});
    check("lat_route_r3", {29'd0, d3_request}, {29'd0, PORT_SOUTH});
    check("lat_no_valid_edge1", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    check("lat_valid_edge2", {31'd0, valid_out}, 32'd1);
    check("lat_req_dropped", {31'd0, req_valid}, 32'd0);
    @(negedge clk);
    check("lat_relieve", {31'd0, relieve}, 32'd1);
    check("lat_relieve_no_valid", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    check("lat_relieve_end", {31'd0, relieve}, 32'd0);
    check("lat_relieve_once", relieve_cnt - start, 32'd1);
    check("lat_drained", exp_q.size(), 32'd0);

    // Routing / streaming table
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      run_packet($sformatf("vec%0d", v), tbl[v].dest, tbl[v].nflits, tbl[v].exp_r0, tbl[v].exp_r3);
    end

    // Grant withheld with a full buffer
    @(posedge clk); #1;
    status = 1'b0;
    start = relieve_cnt;
    push_flit(mk(FLIT_HEAD, 2'd3), 1'b1);
    push_flit(mk(FLIT_BODY, 2'd3), 1'b1);
    push_flit(mk(FLIT_BODY, 2'd3), 1'b1);
    push_flit(mk(FLIT_TAIL, 2'd3), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req_valid", {31'd0, req_valid}, 32'd1);
      check("hold_request", {29'd0, request}, {29'd0, PORT_EAST});
      check("hold_no_valid_out", {31'd0, valid_out}, 32'd0);
      check("hold_full_ready_in", {31'd0, ready_in}, 32'd0);
    end
    @(posedge clk); #1;
    status = 1'b1;
    finish_packet("hold", start);

    // Back-pressure from the switch toggling every cycle
    @(posedge clk); #1;
    fork
      run_packet("bp", 2'd2, 4, PORT_NORTH, PORT_WEST);
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          ready_out = ~ready_out;
        end
        ready_out = 1'b1;
      end
    join

    // Stray body flit while idle
    @(posedge clk); #1;
    start = relieve_cnt;
    push_flit(mk(FLIT_BODY, 2'd1), 1'b0);
    repeat (3) @(negedge clk);
    check("perr_set", {31'd0, perr}, 32'd1);
    check("perr_no_req", {31'd0, req_valid}, 32'd0);
    check("perr_no_valid", {31'd0, valid_out}, 32'd0);
    check("perr_fifo_empty", {31'd0, ready_in}, 32'd1);
    check("perr_no_relieve", relieve_cnt - start, 32'd0);
    @(posedge clk); #1;
    run_packet("after_err", 2'd1, 2, PORT_EAST, PORT_SOUTH);
    check("perr_sticky", {31'd0, perr}, 32'd1);

    // Reset in the middle of a stalled stream
    @(posedge clk); #1;
    ready_out = 1'b0;
    push_flit(mk(FLIT_HEAD, 2'd3), 1'b1);
    push_flit(mk(FLIT_BODY, 2'd3), 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out) begin seen = 1'b1; break; end
    end
    check("mid_streaming", {31'd0, seen}, 32'd1);
    if (seen) check("mid_head_data", {24'd0, data_out}, {24'd0, exp_q[0]});
    #2 rst = 1'b0;
    #1;
    check("mrst_ready_in", {31'd0, ready_in}, 32'd1);
    check("mrst_valid_out", {31'd0, valid_out}, 32'd0);
    check("mrst_data_out", {24'd0, data_out}, 32'd0);
    check("mrst_req", {28'd0, req_valid, request}, 32'd0);
    check("mrst_relieve", {31'd0, relieve}, 32'd0);
    check("mrst_perr", {31'd0, perr}, 32'd0);
    exp_q.delete();
    ready_out = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    run_packet("post_rst", 2'd2, 3, PORT_NORTH, PORT_WEST);
    check("post_rst_perr", {31'd0, perr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
